// File: rtl/brch_ckpt_fifo.sv
// brch_ckpt_fifo -- branch checkpoint queue.
//
// Holds up to DEPTH in-flight branch checkpoints {indx, pos} in age order.
// Branches are appended from up to LANES allocation lanes per cycle, retired
// from the head on commit, and on a mispredict the queue is cut back to the
// oldest entry carrying the mispredicted index, whose contents are returned
// for rename-state recovery one cycle later.
//
// Optional feature: define BRCH_CKPT_STATS_EN to build the saturating
// allocation / flush statistics counters. Without it the stat ports read 0.
//
// Ports:
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   alloc_vld           per-lane allocate request, lane 0 is the oldest
//   alloc_indx/pos      per-lane branch index / checkpoint position (packed)
//   cmt_brch(_indx)     oldest branch commits, with its index
//   mis_pred, brch_mis_indx  mispredict and the offending branch index
//   full, empty, count  occupancy (from registered state only)
//   rcvr_vld/indx/pos   one-cycle recovery pulse with the matched entry
//   err                 sticky: overflow, commit mismatch, mispredict miss
//   stat_alloc/flush    statistics counters
module brch_ckpt_fifo #(
  parameter int DEPTH = 4,
  parameter int LANES = 4,
  parameter int IDX_W = 6,
  parameter int POS_W = 7
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [LANES-1:0]             alloc_vld,
  input  logic [LANES*IDX_W-1:0]       alloc_indx,
  input  logic [LANES*POS_W-1:0]       alloc_pos,
  input  logic                         cmt_brch,
  input  logic [IDX_W-1:0]             cmt_brch_indx,
  input  logic                         mis_pred,
  input  logic [IDX_W-1:0]             brch_mis_indx,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         rcvr_vld,
  output logic [IDX_W-1:0]             rcvr_indx,
  output logic [POS_W-1:0]             rcvr_pos,
  output logic                         err,
  output logic [15:0]                  stat_alloc,
  output logic [15:0]                  stat_flush
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);
  // Wide enough to hold count + LANES without wrapping for the overflow test.
  localparam int SUM_W = CNT_W + 3;

  logic [PTR_W-1:0] r_head, r_tail;
  logic [CNT_W-1:0] r_count;
  logic             r_rcvr_vld, r_err;
  logic [IDX_W-1:0] r_rcvr_indx;
  logic [POS_W-1:0] r_rcvr_pos;
  logic [IDX_W-1:0] r_mem_indx [DEPTH];
  logic [POS_W-1:0] r_mem_pos  [DEPTH];

  logic [2:0]       w_lane_off [LANES];
  logic [2:0]       w_alloc_n;
  logic             w_cmt_ok, w_cmt_err;
  logic [PTR_W-1:0] w_head_eff;
  logic [CNT_W-1:0] w_count_eff;
  logic             w_mis_hit;
  logic [CNT_W-1:0] w_mis_off;
  logic [PTR_W-1:0] w_mis_slot;
  logic             w_ovf, w_alloc_ok, w_err_set;
  logic [PTR_W-1:0] w_tail_next;
  logic [CNT_W-1:0] w_count_next;

  // Write offset of each lane = number of asserted lanes below it, so gaps
  // in alloc_vld are squeezed out and entries land contiguously at the tail.
  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane_off
    if (gi == 0) begin : g_first
      assign w_lane_off[gi] = 3'd0;
    end else begin : g_rest
      assign w_lane_off[gi] = w_lane_off[gi-1] + {2'b00, alloc_vld[gi-1]};
    end
  end
  assign w_alloc_n = w_lane_off[LANES-1] + {2'b00, alloc_vld[LANES-1]};

  // Commit is resolved first; the mispredict search and the overflow check
  // both see the queue as it stands after a successful pop.
  assign w_cmt_ok    = cmt_brch && (r_count != '0) && (r_mem_indx[r_head] == cmt_brch_indx);
  assign w_cmt_err   = cmt_brch && !w_cmt_ok;
  assign w_head_eff  = r_head + PTR_W'(w_cmt_ok);
  assign w_count_eff = r_count - CNT_W'(w_cmt_ok);

  // Oldest-match search: scan youngest to oldest so the oldest hit is the
  // last one written. A mispredict naming the branch being committed this
  // cycle is a miss, since that branch has already left the queue.
  always_comb begin
    logic [PTR_W-1:0] v_slot;
    w_mis_hit = 1'b0;
    w_mis_off = '0;
    v_slot    = '0;
    if (mis_pred && !(w_cmt_ok && (brch_mis_indx == cmt_brch_indx))) begin
      for (int k = DEPTH-1; k >= 0; k--) begin
        v_slot = w_head_eff + PTR_W'(k);
        if ((CNT_W'(k) < w_count_eff) && (r_mem_indx[v_slot] == brch_mis_indx)) begin
          w_mis_hit = 1'b1;
          w_mis_off = CNT_W'(k);
        end
      end
    end
  end
  assign w_mis_slot = w_head_eff + PTR_W'(w_mis_off);

  // Allocation lanes are ignored outright in a mispredict cycle.
  assign w_ovf      = !mis_pred && ((SUM_W'(w_count_eff) + SUM_W'(w_alloc_n)) > SUM_W'(DEPTH));
  assign w_alloc_ok = !mis_pred && !w_ovf && (w_alloc_n != 3'd0);
  assign w_err_set  = w_cmt_err || (mis_pred && !w_mis_hit) || w_ovf;

  always_comb begin
    w_tail_next  = r_tail;
    w_count_next = w_count_eff;
    if (w_mis_hit) begin
      // Matched entry and everything younger are discarded.
      w_tail_next  = w_mis_slot;
      w_count_next = w_mis_off;
    end else if (w_alloc_ok) begin
      w_tail_next  = r_tail + PTR_W'(w_alloc_n);
      w_count_next = w_count_eff + CNT_W'(w_alloc_n);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_head      <= '0;
      r_tail      <= '0;
      r_count     <= '0;
      r_rcvr_vld  <= 1'b0;
      r_rcvr_indx <= '0;
      r_rcvr_pos  <= '0;
      r_err       <= 1'b0;
    end else begin
      r_head     <= w_head_eff;
      r_tail     <= w_tail_next;
      r_count    <= w_count_next;
      r_rcvr_vld <= w_mis_hit;
      if (w_mis_hit) begin
        r_rcvr_indx <= r_mem_indx[w_mis_slot];
        r_rcvr_pos  <= r_mem_pos[w_mis_slot];
      end
      if (w_err_set) r_err <= 1'b1;
    end
  end

  // Entry storage carries no reset; validity is tracked by head/count.
  always_ff @(posedge clk) begin
    for (int k = 0; k < LANES; k++) begin
      if (w_alloc_ok && alloc_vld[k]) begin
        r_mem_indx[r_tail + PTR_W'(w_lane_off[k])] <= alloc_indx[k*IDX_W +: IDX_W];
        r_mem_pos[r_tail + PTR_W'(w_lane_off[k])]  <= alloc_pos[k*POS_W +: POS_W];
      end
    end
  end

  assign count     = r_count;
  assign empty     = (r_count == '0);
  assign full      = (SUM_W'(r_count) + SUM_W'(LANES)) > SUM_W'(DEPTH);
  assign rcvr_vld  = r_rcvr_vld;
  assign rcvr_indx = r_rcvr_indx;
  assign rcvr_pos  = r_rcvr_pos;
  assign err       = r_err;

`ifdef BRCH_CKPT_STATS_EN
  logic [15:0] r_stat_alloc, r_stat_flush;
  logic [16:0] w_alloc_sum;

  assign w_alloc_sum = {1'b0, r_stat_alloc} + 17'(w_alloc_n);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stat_alloc <= '0;
      r_stat_flush <= '0;
    end else begin
      if (w_alloc_ok)
        r_stat_alloc <= w_alloc_sum[16] ? 16'hFFFF : w_alloc_sum[15:0];
      if (w_mis_hit && (r_stat_flush != 16'hFFFF))
        r_stat_flush <= r_stat_flush + 16'd1;
    end
  end

  assign stat_alloc = r_stat_alloc;
  assign stat_flush = r_stat_flush;
`else
  assign stat_alloc = 16'h0000;
  assign stat_flush = 16'h0000;
`endif

endmodule

// File: doc/brch_ckpt_fifo.md
BRCH_CKPT_FIFO -- requirements
Module: brch_ckpt_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 4, checkpoint entries (power of 2, 2..32).
REQ-002 SHALL have parameter LANES, default 4, branch allocation lanes per cycle (1..4).
REQ-003 SHALL have parameter IDX_W, default 6, active-list index width.
REQ-004 SHALL have parameter POS_W, default 7, free-list checkpoint position width.
REQ-005 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-006 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have port alloc_vld  input  LANES  per-lane branch allocate; lane 0 oldest.
REQ-008 SHALL have port alloc_indx  input  LANES*IDX_W  per-lane branch index; lane i at [i*IDX_W +: IDX_W].
REQ-009 SHALL have port alloc_pos  input  LANES*POS_W  per-lane checkpoint position.
REQ-010 SHALL have port cmt_brch  input  1  oldest branch commits.
REQ-011 SHALL have port cmt_brch_indx  input  IDX_W  index of committing branch.
REQ-012 SHALL have port mis_pred  input  1  branch mispredict.
REQ-013 SHALL have port brch_mis_indx  input  IDX_W  index of mispredicted branch.
REQ-014 SHALL have port full  output  1  fewer than LANES free entries.
REQ-015 SHALL have port empty  output  1  no valid entries.
REQ-016 SHALL have port count  output  $clog2(DEPTH+1)  valid entries.
REQ-017 SHALL have port rcvr_vld  output  1  one-cycle recovery pulse.
REQ-018 SHALL have ports rcvr_indx  output  IDX_W and rcvr_pos  output  POS_W  recovered entry contents.
REQ-019 SHALL have port err  output  1  sticky error (overflow, commit mismatch, mispredict miss).
REQ-020 SHALL have ports stat_alloc  output  16 and stat_flush  output  16  statistics counters.

Function
REQ-021 SHALL hold a circular buffer of DEPTH entries {indx, pos} with head/tail pointers of $clog2(DEPTH) bits, wrapping modulo DEPTH, plus a separate count.
REQ-022 SHALL append asserted alloc lanes in lane order at tail, compacting gaps (e.g. alloc_vld=4'b1010 writes lane1 then lane3); tail advances by popcount; entries visible next cycle.
REQ-023 SHALL drop the whole cycle's allocations and set err if count - commit + popcount(alloc_vld) > DEPTH; no partial write.
REQ-024 SHALL on cmt_brch with non-empty queue and head indx == cmt_brch_indx pop head next cycle; on mismatch or empty, no pop and set err.
REQ-025 SHALL on mis_pred search valid entries for indx == brch_mis_indx, selecting the oldest match; set tail to that entry's slot (entry and all younger discarded), recomputing count.
REQ-026 SHALL assert rcvr_vld for exactly one cycle, the cycle after mis_pred, with rcvr_indx/rcvr_pos of the matched entry; no match -> no pulse, no state change, err set.
REQ-027 SHALL ignore all alloc_vld lanes in a mis_pred cycle.
REQ-028 SHALL process simultaneous cmt_brch and mis_pred as commit first, then mispredict search over the remaining entries; mispredict of the committing head -> commit wins, mispredict treated as miss.
REQ-029 SHALL allow simultaneous alloc and commit; freed slot usable same cycle for the overflow check.
REQ-030 SHALL drive full, empty, count combinationally from registered state only.

Reset
REQ-031 SHALL on rst_n low immediately clear head, tail, count, rcvr_vld, rcvr_indx, rcvr_pos, err, stat_alloc, stat_flush; entry storage need not be cleared.
REQ-032 SHALL after reset show empty=1, full=0, count=0; reset mid-mispredict suppresses the pending rcvr_vld.

Configuration
REQ-033 SHALL with macro BRCH_CKPT_STATS_EN defined increment stat_alloc by accepted allocations per cycle and stat_flush by 1 per successful mispredict, both saturating at 16'hFFFF.
REQ-034 SHALL without BRCH_CKPT_STATS_EN keep stat_alloc and stat_flush ports, tied to 16'h0000, with no counter registers.

Verification
REQ-035 SHALL cover: reset, alloc_vld=4'b1111 indx 1,2,3,4 -> next cycle count=4, full=1, head indx=1.
REQ-036 SHALL cover: fill 4 entries, cmt_brch indx 1 and alloc_vld=4'b0001 indx 5 same cycle -> count=4, no err, head indx=2.
REQ-037 SHALL cover: entries indx 2,3,4,5 pos 10,11,12,13, mis_pred indx 4 -> next cycle rcvr_vld=1, rcvr_pos=12, count=2, tail at old slot of indx 4.
REQ-038 SHALL cover: 5 allocations over wrap-around (DEPTH=4, head at slot 3) -> overflow, err=1, count unchanged.
REQ-039 SHALL cover: cmt_brch indx 7 while head indx 2 -> no pop, err=1; mis_pred indx 9 absent -> rcvr_vld stays 0.
REQ-040 SHALL cover: with BRCH_CKPT_STATS_EN, 3 allocations + 1 flush -> stat_alloc=3, stat_flush=1; without it, both 0.
